// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM target: command codes, address width
// and the transaction state type.
package spi_sram_pkg;

  localparam logic [7:0]  CMD_READ        = 8'h03;
  localparam logic [7:0]  CMD_WRITE       = 8'h02;
  localparam int unsigned SPI_SRAM_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WRITE,
    ST_FETCH,
    ST_READ,
    ST_IGNORE
  } spi_tgt_state_t;

endpackage

// File: rtl/spi_sram_target_if.sv
// Byte-wide synchronous memory port between the SPI target (master) and its
// backing store (slave); read data returns one clk after mem_re.
interface spi_sram_target_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/spi_pin_sync.sv
// N-stage synchronizers for the SPI pins plus a registered edge detector on SCLK;
// every output lags its pin by SYNC_STAGES+1 clk.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_cs_n,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_mosi_s,
  output logic o_cs_active
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_n_sync;
  logic                   r_sclk_d;
  logic                   r_mosi_d;
  logic                   r_cs_d;
  logic                   r_rise;
  logic                   r_fall;

  // Synchronizer chains are left unreset so CS keeps tracking the pin through a
  // reset; the top relies on that to wait for a genuinely fresh CS assertion.
  always_ff @(posedge clk) begin
    r_sclk_sync[0] <= i_sclk;
    r_mosi_sync[0] <= i_mosi;
    r_cs_n_sync[0] <= i_cs_n;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      r_sclk_sync[i] <= r_sclk_sync[i-1];
      r_mosi_sync[i] <= r_mosi_sync[i-1];
      r_cs_n_sync[i] <= r_cs_n_sync[i-1];
    end
    r_sclk_d <= r_sclk_sync[SYNC_STAGES-1];
    r_mosi_d <= r_mosi_sync[SYNC_STAGES-1];
    r_cs_d   <= ~r_cs_n_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
      r_fall <= ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
    end
  end

  assign o_sclk_rise = r_rise;
  assign o_sclk_fall = r_fall;
  assign o_mosi_s    = r_mosi_d;
  assign o_cs_active = r_cs_d;

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 target emulating a 64 KiB serial SRAM (READ 0x03 / WRITE 0x02,
// 16-bit address, sequential mode) over a byte-wide synchronous memory port.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = SPI_SRAM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_spi_clk,
  input  logic               i_spi_mosi,
  input  logic               i_spi_cs_n,
  output logic               o_spi_miso,
  output logic               o_busy,
  spi_sram_target_if.master  mem
);

  logic w_rise, w_fall, w_mosi, w_cs;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk         (clk),
    .rst         (rst),
    .i_sclk      (i_spi_clk),
    .i_mosi      (i_spi_mosi),
    .i_cs_n      (i_spi_cs_n),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall),
    .o_mosi_s    (w_mosi),
    .o_cs_active (w_cs)
  );

  spi_tgt_state_t    r_state, w_state_n;
  logic              r_armed, w_armed_n;
  logic              r_is_read, w_is_read_n;
  logic [3:0]        r_bitcnt, w_bitcnt_n;
  logic [14:0]       r_shift, w_shift_n;
  logic [15:0]       w_bit_shift;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
  logic [7:0]        r_wdata, w_wdata_n;
  logic              r_we, w_we_n;
  logic              r_re, w_re_n;
  logic              r_rvalid;
  logic [6:0]        r_obuf, w_obuf_n;
  logic [7:0]        r_pref, w_pref_n;
  logic              r_miso, w_miso_n;

  assign w_bit_shift = {r_shift, w_mosi};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_is_read  <= 1'b0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_rvalid   <= 1'b0;
      r_obuf     <= '0;
      r_pref     <= '0;
      r_miso     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_armed    <= w_armed_n;
      r_is_read  <= w_is_read_n;
      r_bitcnt   <= w_bitcnt_n;
      r_shift    <= w_shift_n;
      r_addr     <= w_addr_n;
      r_mem_addr <= w_mem_addr_n;
      r_wdata    <= w_wdata_n;
      r_we       <= w_we_n;
      r_re       <= w_re_n;
      r_rvalid   <= r_re;
      r_obuf     <= w_obuf_n;
      r_pref     <= w_pref_n;
      r_miso     <= w_miso_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_armed_n    = r_armed | ~w_cs;
    w_is_read_n  = r_is_read;
    w_bitcnt_n   = r_bitcnt;
    w_shift_n    = r_shift;
    w_addr_n     = r_addr;
    w_mem_addr_n = r_mem_addr;
    w_wdata_n    = r_wdata;
    w_we_n       = 1'b0;
    w_re_n       = 1'b0;
    w_obuf_n     = r_obuf;
    w_pref_n     = r_pref;
    w_miso_n     = 1'b0;

    unique case (r_state)
      // Armed only after CS has been seen inactive, so a reset mid-frame waits
      // for the next fresh assertion.
      ST_IDLE: begin
        if (w_cs && r_armed) begin
          w_state_n  = ST_CMD;
          w_bitcnt_n = '0;
          w_shift_n  = '0;
        end
      end
      ST_CMD: begin
        if (w_rise) begin
          w_shift_n  = w_bit_shift[14:0];
          w_bitcnt_n = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            w_bitcnt_n = '0;
            if (w_bit_shift[7:0] == CMD_WRITE) begin
              w_state_n   = ST_ADDR;
              w_is_read_n = 1'b0;
            end else if (w_bit_shift[7:0] == CMD_READ) begin
              w_state_n   = ST_ADDR;
              w_is_read_n = 1'b1;
            end else begin
              w_state_n = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (w_rise) begin
          w_shift_n  = w_bit_shift[14:0];
          w_bitcnt_n = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd15) begin
            w_bitcnt_n = '0;
            w_addr_n   = w_bit_shift[ADDR_W-1:0];
            if (r_is_read) begin
              w_state_n    = ST_FETCH;
              w_re_n       = 1'b1;
              w_mem_addr_n = w_bit_shift[ADDR_W-1:0];
            end else begin
              w_state_n = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (w_rise) begin
          w_shift_n  = w_bit_shift[14:0];
          w_bitcnt_n = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            w_bitcnt_n   = '0;
            w_we_n       = 1'b1;
            w_wdata_n    = w_bit_shift[7:0];
            w_mem_addr_n = r_addr;
            w_addr_n     = r_addr + ADDR_W'(1);
          end
        end
      end
      // First read was issued on the last address bit; while it is in flight
      // the prefetch for addr+1 goes out, then the first byte is loaded.
      ST_FETCH: begin
        if (r_rvalid) begin
          w_obuf_n   = mem.mem_rdata[6:0];
          w_miso_n   = mem.mem_rdata[7];
          w_bitcnt_n = '0;
          w_state_n  = ST_READ;
        end else if (r_re) begin
          w_re_n       = 1'b1;
          w_mem_addr_n = r_addr + ADDR_W'(1);
        end
      end
      // bitcnt counts rises in the current byte; the fall that follows a load
      // must not shift, hence the nonzero guard.
      ST_READ: begin
        w_miso_n = r_miso;
        if (r_rvalid) begin
          w_pref_n = mem.mem_rdata;
        end
        if (w_rise) begin
          w_bitcnt_n = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) begin
            w_bitcnt_n   = '0;
            w_obuf_n     = r_pref[6:0];
            w_miso_n     = r_pref[7];
            w_addr_n     = r_addr + ADDR_W'(1);
            w_re_n       = 1'b1;
            w_mem_addr_n = r_addr + ADDR_W'(2);
          end
        end else if (w_fall && r_bitcnt != 4'd0) begin
          w_miso_n = r_obuf[6];
          w_obuf_n = {r_obuf[5:0], 1'b0};
        end
      end
      ST_IGNORE: begin
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    if (!w_cs) begin
      w_state_n = ST_IDLE;
      w_we_n    = 1'b0;
      w_re_n    = 1'b0;
      w_miso_n  = 1'b0;
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_busy        = w_cs & r_armed;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_we    = r_we;
  assign mem.mem_re    = r_re;

endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: drives SPI frames at pin level, models the backing
// memory, and checks against a transaction-level view of the SRAM contents.
module tb_spi_sram_target;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = SYNC + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic miso;
  logic busy;

  spi_sram_target_if #(.ADDR_W(16)) mem_bus ();

  spi_sram_target #(.SYNC_STAGES(SYNC), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_spi_clk  (sclk),
    .i_spi_mosi (mosi),
    .i_spi_cs_n (cs_n),
    .o_spi_miso (miso),
    .o_busy     (busy),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: one-cycle read latency; preload port for the bench.
  logic [7:0]  tb_mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  always @(posedge clk) begin
    if (mem_bus.mem_re) mem_bus.mem_rdata <= tb_mem[mem_bus.mem_addr];
    if (mem_bus.mem_we) tb_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    if (pl_en) tb_mem[pl_addr] <= pl_data;
  end

  // Strobe monitor.
  logic [23:0] wq [$];
  int          wcyc_q [$];
  int          re_cnt = 0;
  int          both_cnt = 0;
  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      wq.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
      wcyc_q.push_back(cyc);
    end
    if (mem_bus.mem_re) re_cnt++;
    if (mem_bus.mem_we && mem_bus.mem_re) both_cnt++;
  end

  // Reference model: SRAM contents as the initiator should see them.
  logic [7:0]  ref_mem [0:65535];
  logic [23:0] exp_q [$];
  int          rise_q [$];
  int          wr_ptr = 0;
  int          last_rise = 0;
  logic [7:0]  dbuf [0:7];
  logic [31:0] rword;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      sclk = 1'b1;
      last_rise = cyc;
      rx = {rx[6:0], miso};
      wait_clk(HALF);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic cs_on();
    cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_off();
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF + 4);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_writes();
    chk("wr_count", wq.size() - wr_ptr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (wr_ptr + i < wq.size()) begin
        chk("wr_addr", {16'h0, wq[wr_ptr+i][23:8]}, {16'h0, exp_q[i][23:8]});
        chk("wr_data", {24'h0, wq[wr_ptr+i][7:0]}, {24'h0, exp_q[i][7:0]});
        chk("wr_latency", wcyc_q[wr_ptr+i] - rise_q[i], SYNC + 2);
      end
    end
    wr_ptr = wq.size();
    exp_q.delete();
    rise_q.delete();
  endtask

  task automatic write_txn(input logic [15:0] a, input int len);
    logic [7:0]  rx;
    logic [15:0] ai;
    cs_on();
    chk("busy_hi", busy, 1'b1);
    spi_bits(8'h02, 8, rx);
    spi_bits(a[15:8], 8, rx);
    spi_bits(a[7:0], 8, rx);
    for (int i = 0; i < len; i++) begin
      ai = a + 16'(i);
      spi_bits(dbuf[i], 8, rx);
      rise_q.push_back(last_rise);
      exp_q.push_back({ai, dbuf[i]});
      ref_mem[ai] = dbuf[i];
    end
    cs_off();
    chk("busy_lo", busy, 1'b0);
    check_writes();
  endtask

  task automatic read_txn(input logic [15:0] a, input int len);
    logic [7:0]  rx;
    logic [15:0] ai;
    int          re0;
    re0 = re_cnt;
    rword = '0;
    cs_on();
    spi_bits(8'h03, 8, rx);
    spi_bits(a[15:8], 8, rx);
    spi_bits(a[7:0], 8, rx);
    for (int i = 0; i < len; i++) begin
      ai = a + 16'(i);
      spi_bits(8'($urandom), 8, rx);
      chk("rd_byte", {24'h0, rx}, {24'h0, ref_mem[ai]});
      rword = {rword[23:0], rx};
    end
    cs_off();
    chk("rd_re_count", re_cnt - re0, len + 2);
    chk("rd_no_write", wq.size() - wr_ptr, 0);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [7:0]  acc;
    logic [15:0] a;
    int          len;
    int          re0;

    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

    wait_clk(8);
    chk("rst_miso", miso, 1'b0);
    chk("rst_we", mem_bus.mem_we, 1'b0);
    chk("rst_re", mem_bus.mem_re, 1'b0);
    chk("rst_addr", {16'h0, mem_bus.mem_addr}, 32'h0);
    chk("rst_wdata", {24'h0, mem_bus.mem_wdata}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    // Single write.
    dbuf[0] = 8'hA5;
    write_txn(16'h1234, 1);

    // Sequential write across the top of the address space.
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    write_txn(16'hFFFF, 2);

    // 32-bit read.
    preload(16'h1000, 8'hDE);
    preload(16'h1001, 8'hAD);
    preload(16'h1002, 8'hBE);
    preload(16'h1003, 8'hEF);
    read_txn(16'h1000, 4);
    chk("rd_word", rword, 32'hDEADBEEF);

    // Unknown command is ignored.
    re0 = re_cnt;
    acc = '0;
    cs_on();
    spi_bits(8'h05, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'($urandom), 8, rx);
      acc = acc | rx;
    end
    cs_off();
    chk("ign_miso", {24'h0, acc}, 32'h0);
    chk("ign_re", re_cnt - re0, 0);
    chk("ign_we", wq.size() - wr_ptr, 0);

    // Partial data byte then CS release: no write.
    cs_on();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h40, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs_off();
    chk("abort_we", wq.size() - wr_ptr, 0);
    chk("abort_busy", busy, 1'b0);
    dbuf[0] = 8'h7E;
    write_txn(16'h0010, 1);

    // Reset in the middle of a read.
    preload(16'h4321, 8'h5A);
    preload(16'h4322, 8'hC3);
    cs_on();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h43, 8, rx);
    spi_bits(8'h21, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("pre_rst_byte", {24'h0, rx}, 32'h5A);
    spi_bits(8'h00, 3, rx);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_we", mem_bus.mem_we, 1'b0);
    chk("midrst_re", mem_bus.mem_re, 1'b0);
    chk("midrst_addr", {16'h0, mem_bus.mem_addr}, 32'h0);
    chk("midrst_wdata", {24'h0, mem_bus.mem_wdata}, 32'h0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(2);
    chk("post_rst_busy", busy, 1'b0);
    cs_n = 1'b1;
    wait_clk(HALF + 4);
    chk("post_rst_we", wq.size() - wr_ptr, 0);
    read_txn(16'h4321, 2);

    // Randomized write-then-read-back and fresh-region reads.
    for (int it = 0; it < 10; it++) begin
      a = 16'($urandom);
      if (it % 4 == 0) a = 16'hFFFE;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) dbuf[i] = 8'($urandom);
      write_txn(a, len);
      read_txn(a, len);
      a = 16'($urandom);
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) preload(a + 16'(i), 8'($urandom));
      read_txn(a, len);
    end

    chk("no_we_re_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
